skin_region_stats: RTL and testbench
====================================

Name: skin_region_stats

Overview:
- Downstream consumer of the skintone detector's per-pixel `valid_out`/`skinScore` stream.
- Thresholds each score into a skin/non-skin decision and tracks raster position over a fixed WIDTH x HEIGHT frame.
- Accumulates the per-frame skin pixel count and skin bounding box, then publishes registered results with a one-cycle `frame_done` pulse for the downstream face-localisation logic.

Parameters:
- WIDTH, 640, active pixels per line.
- HEIGHT, 480, lines per frame.
- XW, 10, x coordinate width (>= clog2(WIDTH)).
- YW, 9, y coordinate width (>= clog2(HEIGHT)).
- CW, 19, skin count width (>= clog2(WIDTH*HEIGHT+1)).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- valid_in  in  1  skinScore valid, one pixel per asserted cycle, raster order.
- skinScore  in  8  detector score, unsigned.
- threshold  in  8  pixel is skin when skinScore >= threshold; sampled per pixel.
- frame_done  out  1  one-cycle pulse, results below updated this cycle.
- skin_count  out  CW  skin pixels in last completed frame.
- bbox_valid  out  1  at least one skin pixel in last frame.
- x_min  out  XW  leftmost skin column, last frame.
- x_max  out  XW  rightmost skin column, last frame.
- y_min  out  YW  top skin line, last frame.
- y_max  out  YW  bottom skin line, last frame.

Behaviour:
- Reset: all outputs 0. x/y counters 0, accumulators cleared, FSM in ACCUM.
- Pixel accepted only on valid_in=1. Gaps of any length are allowed and hold all state.
- Position counters:
  - x increments per accepted pixel.
  - At x=WIDTH-1, x wraps to 0 and y increments.
  - At x=WIDTH-1 and y=HEIGHT-1 (last pixel), both wrap to 0.
- skin = (skinScore >= threshold), unsigned 8-bit compare. threshold=0 makes every pixel skin.
- Accumulation on a skin pixel:
  - count += 1.
  - Min/max registers updated against the current x,y.
  - A first-hit flag forces min=max=current on the first skin pixel of the frame.
- FSM states:
  - ACCUM: accumulate. The last pixel accepted moves the FSM to REPORT.
  - REPORT (one cycle): copy the final accumulators, including the last pixel's contribution, into output registers; assert frame_done; clear accumulators and first-hit; return to ACCUM.
- Latency: frame_done asserts exactly 1 cycle after the clock edge accepting the last pixel.
- Pixel during REPORT: valid_in=1 is accepted as pixel (0,0) of the next frame and accumulates into the freshly cleared state. No back-pressure, no drop.
- No skin in frame: skin_count=0, bbox_valid=0, bbox outputs forced 0.
- Output registers hold between frame_done pulses.
- Count saturation: not required, since CW is sized for the full frame.
- rst mid-frame: the partial frame is discarded, outputs return to 0, and the next accepted pixel is (0,0).

Optional Feature:
- Macro `SKIN_MASK_OUT_EN`.
- When defined:
  - Adds outputs mask_valid (1) and mask (1): the registered per-pixel skin decision, 1-cycle latency from valid_in.
  - Adds mask_sof (1), asserted with the pixel at (0,0).
  - All three reset to 0.
- When undefined: these ports and their logic are absent; the statistics behaviour is unchanged.

Decomposition:
- Package `skin_stats_pkg`: FSM state enum (ACCUM, REPORT), default WIDTH/HEIGHT constants, and a packed bbox struct {x_min, x_max, y_min, y_max}.
- Sub-module `raster_counter`:
  - Parameterised WIDTH/HEIGHT x/y counter with an advance enable.
  - Outputs x, y and a last_pixel flag.
  - Reusable by other per-frame stages.

Test Plan:
- 4x3 frame (WIDTH=4, HEIGHT=3), threshold=128, all scores 0 -> frame_done once after the 12th pixel; skin_count=0; bbox_valid=0; bbox all 0.
- 4x3, score 254 only at (1,0) and (2,2), rest 0 -> skin_count=2; x_min=1, x_max=2, y_min=0, y_max=2; bbox_valid=1.
- 4x3, threshold=0, valid_in toggling every other cycle -> skin_count=12; bbox (0,3,0,2); frame_done 1 cycle after the last accepted pixel.
- Two back-to-back frames with no gap, frame 1 all 255, frame 2 a single 255 at (3,1) -> pixel during REPORT is counted in frame 2; second report skin_count=1, bbox (3,3,1,1).
- rst asserted after 7 pixels of a frame, then a full frame with a single skin pixel at (0,0) -> outputs 0 during reset; one frame_done with skin_count=1 and bbox (0,0,0,0).
- With `SKIN_MASK_OUT_EN`, scores {90,200} at threshold 128 -> mask=0 then 1, each 1 cycle after input; mask_sof on the first pixel only.

Source files
------------

// File: rtl/skin_region_stats_pkg.sv
// Shared types for the skin region statistics stage: FSM state, default frame
// geometry and the bounding-box record.
package skin_stats_pkg;

  localparam int DEF_WIDTH  = 640;
  localparam int DEF_HEIGHT = 480;

  // Box fields are kept wide enough for any supported geometry; users slice.
  localparam int BOX_W = 16;

  typedef enum logic [0:0] {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } state_t;

  typedef struct packed {
    logic [BOX_W-1:0] x_min;
    logic [BOX_W-1:0] x_max;
    logic [BOX_W-1:0] y_min;
    logic [BOX_W-1:0] y_max;
  } bbox_t;

endpackage

// File: rtl/skin_region_stats_raster_counter.sv
// Raster position tracker: x/y over a WIDTH x HEIGHT frame, advanced once per
// accepted pixel, with a flag marking the final pixel of the frame.
module raster_counter
  import skin_stats_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int XW     = 10,
  parameter int YW     = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last_pixel
);

  logic x_end;
  logic y_end;

  assign x_end      = (x == XW'(WIDTH - 1));
  assign y_end      = (y == YW'(HEIGHT - 1));
  assign last_pixel = x_end && y_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x_end) begin
        x <= '0;
        y <= y_end ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

endmodule

// File: rtl/skin_region_stats.sv
// Per-frame skin pixel count and bounding box from the skinScore stream.
// Optional SKIN_MASK_OUT_EN adds a registered per-pixel mask output.
module skin_region_stats
  import skin_stats_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int XW     = 10,
  parameter int YW     = 9,
  parameter int CW     = 19
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_in,
  input  logic [7:0]    skinScore,
  input  logic [7:0]    threshold,
  output logic          frame_done,
  output logic [CW-1:0] skin_count,
  output logic          bbox_valid,
  output logic [XW-1:0] x_min,
  output logic [XW-1:0] x_max,
  output logic [YW-1:0] y_min,
  output logic [YW-1:0] y_max
`ifdef SKIN_MASK_OUT_EN
  ,
  output logic          mask_valid,
  output logic          mask,
  output logic          mask_sof
`endif
);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          last_pixel;
  logic          skin;
  state_t        state;

  logic [CW-1:0] acc_count, base_count, nxt_count;
  logic          acc_hit, base_hit, nxt_hit;
  bbox_t         acc_box, base_box, nxt_box;
  logic [BOX_W-1:0] px, py;

  raster_counter #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .XW    (XW),
    .YW    (YW)
  ) u_raster (
    .clk       (clk),
    .rst       (rst),
    .advance   (valid_in),
    .x         (x),
    .y         (y),
    .last_pixel(last_pixel)
  );

  assign skin = (skinScore >= threshold);
  assign px   = BOX_W'(x);
  assign py   = BOX_W'(y);

  // In REPORT the accumulators restart from zero so a pixel arriving in that
  // cycle lands in the new frame.
  always_comb begin
    base_count = (state == REPORT) ? '0 : acc_count;
    base_hit   = (state == REPORT) ? 1'b0 : acc_hit;
    base_box   = (state == REPORT) ? '0 : acc_box;
    nxt_count  = base_count;
    nxt_hit    = base_hit;
    nxt_box    = base_box;
    if (valid_in && skin) begin
      nxt_count = base_count + CW'(1);
      nxt_hit   = 1'b1;
      if (!base_hit) begin
        nxt_box = '{x_min: px, x_max: px, y_min: py, y_max: py};
      end else begin
        if (px < base_box.x_min) nxt_box.x_min = px;
        if (px > base_box.x_max) nxt_box.x_max = px;
        if (py < base_box.y_min) nxt_box.y_min = py;
        if (py > base_box.y_max) nxt_box.y_max = py;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ACCUM;
      acc_count  <= '0;
      acc_hit    <= 1'b0;
      acc_box    <= '0;
      frame_done <= 1'b0;
      skin_count <= '0;
      bbox_valid <= 1'b0;
      x_min      <= '0;
      x_max      <= '0;
      y_min      <= '0;
      y_max      <= '0;
    end else begin
      state      <= (valid_in && last_pixel) ? REPORT : ACCUM;
      acc_count  <= nxt_count;
      acc_hit    <= nxt_hit;
      acc_box    <= nxt_box;
      frame_done <= (state == REPORT);
      if (state == REPORT) begin
        skin_count <= acc_count;
        bbox_valid <= acc_hit;
        x_min      <= acc_hit ? acc_box.x_min[XW-1:0] : '0;
        x_max      <= acc_hit ? acc_box.x_max[XW-1:0] : '0;
        y_min      <= acc_hit ? acc_box.y_min[YW-1:0] : '0;
        y_max      <= acc_hit ? acc_box.y_max[YW-1:0] : '0;
      end
    end
  end

`ifdef SKIN_MASK_OUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_valid <= 1'b0;
      mask       <= 1'b0;
      mask_sof   <= 1'b0;
    end else begin
      mask_valid <= valid_in;
      mask       <= valid_in && skin;
      mask_sof   <= valid_in && (x == '0) && (y == '0);
    end
  end
`endif

endmodule

// File: tb/tb_skin_region_stats.sv
// Self-checking bench for skin_region_stats on a 4x3 frame: directed table,
// hand-written corner sequences and random frames against a frame-level model.
module tb_skin_region_stats;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int XW   = 10;
  localparam int YW   = 9;
  localparam int CW   = 19;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_in = 1'b0;
  logic [7:0]    skinScore = '0;
  logic [7:0]    threshold = '0;
  logic          frame_done;
  logic [CW-1:0] skin_count;
  logic          bbox_valid;
  logic [XW-1:0] x_min, x_max;
  logic [YW-1:0] y_min, y_max;
`ifdef SKIN_MASK_OUT_EN
  logic          mask_valid, mask, mask_sof;
`endif

  skin_region_stats #(.WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .skinScore (skinScore),
    .threshold (threshold),
    .frame_done(frame_done),
    .skin_count(skin_count),
    .bbox_valid(bbox_valid),
    .x_min     (x_min),
    .x_max     (x_max),
    .y_min     (y_min),
    .y_max     (y_max)
`ifdef SKIN_MASK_OUT_EN
    ,
    .mask_valid(mask_valid),
    .mask      (mask),
    .mask_sof  (mask_sof)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    integer count, valid, xmin, xmax, ymin, ymax, cyc;
  } rep_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   rep_cnt  = 0;
  rep_t exp_q[$];
  rep_t dut_q[$];
  rep_t last_exp;
  rep_t m_acc;
  int   m_idx = 0;

  task automatic chk(input string name, input integer act, input integer expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic chk_rep(input string tag, input rep_t a, input rep_t e);
    chk({tag, "_count"}, a.count, e.count);
    chk({tag, "_bbox_valid"}, a.valid, e.valid);
    chk({tag, "_x_min"}, a.xmin, e.xmin);
    chk({tag, "_x_max"}, a.xmax, e.xmax);
    chk({tag, "_y_min"}, a.ymin, e.ymin);
    chk({tag, "_y_max"}, a.ymax, e.ymax);
  endtask

  function automatic rep_t dut_now();
    rep_t r;
    r.count = skin_count; r.valid = bbox_valid;
    r.xmin = x_min; r.xmax = x_max; r.ymin = y_min; r.ymax = y_max;
    r.cyc = cyc;
    return r;
  endfunction

  // Frame-level model: pixel index gives the raster position directly.
  task automatic model_pixel(input int s, input int t);
    int px = m_idx % W;
    int py = m_idx / W;
    if (s >= t) begin
      if (m_acc.count == 0) begin
        m_acc.xmin = px; m_acc.xmax = px; m_acc.ymin = py; m_acc.ymax = py;
      end else begin
        if (px < m_acc.xmin) m_acc.xmin = px;
        if (px > m_acc.xmax) m_acc.xmax = px;
        if (py < m_acc.ymin) m_acc.ymin = py;
        if (py > m_acc.ymax) m_acc.ymax = py;
      end
      m_acc.count++;
    end
    m_idx++;
    if (m_idx == NPIX) begin
      m_acc.valid = (m_acc.count > 0);
      m_acc.cyc   = cyc;
      exp_q.push_back(m_acc);
      m_acc = '{default: 0};
      m_idx = 0;
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    rep_t e;
    m_acc    = '{default: 0};
    last_exp = '{default: 0};
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        chk("reset_frame_done", frame_done, 0);
        chk_rep("reset", dut_now(), '{default: 0});
`ifdef SKIN_MASK_OUT_EN
        chk("reset_mask_valid", mask_valid, 0);
        chk("reset_mask", mask, 0);
        chk("reset_mask_sof", mask_sof, 0);
`endif
        exp_q.delete();
        m_acc    = '{default: 0};
        m_idx    = 0;
        last_exp = '{default: 0};
      end else begin
`ifdef SKIN_MASK_OUT_EN
        chk("mask_valid", mask_valid, valid_in);
        chk("mask", mask, valid_in && (skinScore >= threshold));
        chk("mask_sof", mask_sof, valid_in && (m_idx == 0));
`endif
        if (frame_done) begin
          rep_cnt++;
          dut_q.push_back(dut_now());
          if (exp_q.size() == 0) begin
            chk("unexpected_frame_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk_rep("report", dut_now(), e);
            chk("frame_done_latency", cyc, e.cyc + 1);
            last_exp = e;
          end
        end else begin
          chk_rep("hold", dut_now(), last_exp);
        end
        if (valid_in) model_pixel(skinScore, threshold);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t, required < 400000", $time);
    $fatal(1);
  end

  task automatic pix(input logic [7:0] s, input logic [7:0] t);
    @(negedge clk);
    valid_in = 1'b1; skinScore = s; threshold = t;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0; skinScore = 8'($urandom);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; valid_in = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_frame(input logic [NPIX-1:0][7:0] sc, input logic [7:0] t, input bit gap);
    for (int i = 0; i < NPIX; i++) begin
      pix(sc[i], t);
      if (gap) idle(1);
    end
  endtask

  task automatic wait_reports(input int target, input string name);
    for (int k = 0; k < 60; k++) begin
      if (rep_cnt >= target) break;
      @(negedge clk);
    end
    chk({name, "_report_seen"}, (rep_cnt >= target), 1);
  endtask

  typedef struct {
    logic [NPIX-1:0][7:0] sc;
    logic [7:0] thr;
    bit gap;
    rep_t exp;
  } vec_t;

  vec_t tbl[3];

  initial begin
    logic [NPIX-1:0][7:0] f1, f2, f3;
    int base;

    tbl[0].sc = '0;  tbl[0].thr = 8'd128; tbl[0].gap = 1'b0;
    tbl[0].exp = '{count: 0, valid: 0, xmin: 0, xmax: 0, ymin: 0, ymax: 0, cyc: 0};
    tbl[1].sc = '0;  tbl[1].sc[1] = 8'd254; tbl[1].sc[10] = 8'd254;
    tbl[1].thr = 8'd128; tbl[1].gap = 1'b0;
    tbl[1].exp = '{count: 2, valid: 1, xmin: 1, xmax: 2, ymin: 0, ymax: 2, cyc: 0};
    for (int i = 0; i < NPIX; i++) tbl[2].sc[i] = 8'($urandom);
    tbl[2].thr = 8'd0; tbl[2].gap = 1'b1;
    tbl[2].exp = '{count: 12, valid: 1, xmin: 0, xmax: 3, ymin: 0, ymax: 2, cyc: 0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 3; i++) begin
      base = rep_cnt;
      run_frame(tbl[i].sc, tbl[i].thr, tbl[i].gap);
      idle(3);
      wait_reports(base + 1, $sformatf("table%0d", i));
      chk($sformatf("table%0d_single_pulse", i), rep_cnt, base + 1);
      if (dut_q.size() > base) chk_rep($sformatf("table%0d", i), dut_q[base], tbl[i].exp);
    end

    // Back-to-back frames: the first pixel of each later frame hits REPORT.
    f1 = '0; f2 = '0; f3 = '0;
    for (int i = 0; i < NPIX; i++) f1[i] = 8'd255;
    f2[7]  = 8'd255;
    f3[0]  = 8'd255;
    f3[11] = 8'd255;
    base = rep_cnt;
    run_frame(f1, 8'd128, 1'b0);
    run_frame(f2, 8'd128, 1'b0);
    run_frame(f3, 8'd128, 1'b0);
    idle(3);
    wait_reports(base + 3, "b2b");
    if (dut_q.size() > base + 2) begin
      chk_rep("b2b_f1", dut_q[base],
              '{count: 12, valid: 1, xmin: 0, xmax: 3, ymin: 0, ymax: 2, cyc: 0});
      chk_rep("b2b_f2", dut_q[base + 1],
              '{count: 1, valid: 1, xmin: 3, xmax: 3, ymin: 1, ymax: 1, cyc: 0});
      chk_rep("b2b_f3", dut_q[base + 2],
              '{count: 2, valid: 1, xmin: 0, xmax: 3, ymin: 0, ymax: 2, cyc: 0});
    end

    // Reset after 7 pixels, then a frame with one skin pixel at (0,0).
    for (int i = 0; i < 7; i++) pix(8'd255, 8'd0);
    do_reset(3);
    f1 = '0; f1[0] = 8'd255;
    base = rep_cnt;
    run_frame(f1, 8'd128, 1'b0);
    idle(3);
    wait_reports(base + 1, "after_reset");
    chk("after_reset_single_pulse", rep_cnt, base + 1);
    if (dut_q.size() > base)
      chk_rep("after_reset", dut_q[base],
              '{count: 1, valid: 1, xmin: 0, xmax: 0, ymin: 0, ymax: 0, cyc: 0});

`ifdef SKIN_MASK_OUT_EN
    do_reset(2);
    pix(8'd90, 8'd128);
    pix(8'd200, 8'd128);
    idle(2);
    do_reset(2);
`endif

    // Random frames with random gaps and per-pixel thresholds.
    for (int f = 0; f < 24; f++) begin
      int tb_thr = $urandom_range(150, 255);
      if (f == 12) begin
        for (int i = 0; i < 5; i++) pix(8'($urandom), 8'($urandom));
        do_reset(2);
      end
      for (int i = 0; i < NPIX; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        pix(8'($urandom), 8'(tb_thr - $urandom_range(0, 20)));
      end
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 4));
    end
    idle(4);
    chk("pending_reports", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
